tl_ped_cntr: RTL and testbench

TL_PED_CNTR -- requirements
Module: tl_ped_cntr

---
 rtl/tl_ped_cntr_pkg.sv | 19 +
 rtl/tl_ped_cntr_timer.sv | 30 +++
 rtl/tl_ped_cntr.sv | 118 +++++++++++
 tb/tb_tl_ped_cntr.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/tl_ped_cntr_pkg.sv
// Shared light codes and controller state encodings for the traffic-light
// controller family.
package tl_ped_cntr_pkg;

    typedef enum logic [1:0] {
        GREEN  = 2'b00,
        YELLOW = 2'b01,
        RED    = 2'b10
    } light_t;

    typedef enum logic [2:0] {
        ST_AG   = 3'd0,
        ST_AY   = 3'd1,
        ST_BG   = 3'd2,
        ST_BY   = 3'd3,
        ST_WALK = 3'd4
    } state_t;

endpackage

// File: rtl/tl_ped_cntr_timer.sv
// In-state cycle counter: synchronous clear and load, saturates at SAT.
module tl_timer #(
    parameter int W   = 4,
    parameter int SAT = 15
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] SAT_V = W'(SAT);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != SAT_V) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/tl_ped_cntr.sv
// Two-road traffic-light controller with a pedestrian all-red walk phase.
// Moore FSM; lights and walk lamp decode from state only.
module tl_ped_cntr
    import tl_ped_cntr_pkg::*;
#(
    parameter int GREEN_MIN = 4,
    parameter int GREEN_MAX = 16,
    parameter int YELLOW_T  = 2,
    parameter int WALK_T    = 6
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       Ta,
    input  logic       Tb,
    input  logic       ped_req,
    output logic [1:0] La,
    output logic [1:0] Lb,
    output logic       walk,
    output logic       ped_ack
);

    localparam int CW = $clog2(GREEN_MAX);
    localparam logic [CW-1:0] GMIN_LAST = CW'(GREEN_MIN - 1);
    localparam logic [CW-1:0] GMAX_LAST = CW'(GREEN_MAX - 1);
    localparam logic [CW-1:0] YEL_LAST  = CW'(YELLOW_T - 1);
    localparam logic [CW-1:0] WALK_LAST = CW'(WALK_T - 1);

    state_t        state, nxt;
    logic [CW-1:0] cnt;
    logic          ped_pend;
    logic          walk_side_a;   // 1: walk entered from AY, resume with B
    logic          state_chg;
    logic          walk_entry;

    assign state_chg  = (nxt != state);
    assign walk_entry = (nxt == ST_WALK) && (state != ST_WALK);

    tl_timer #(
        .W   (CW),
        .SAT (GREEN_MAX - 1)
    ) u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .clr      (state_chg),
        .load     (1'b0),
        .load_val ('0),
        .cnt      (cnt)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_AG;
            ped_pend    <= 1'b0;
            walk_side_a <= 1'b1;
        end else begin
            state <= nxt;
            // Entry edge wins over a request seen on that same edge.
            if (walk_entry) begin
                ped_pend    <= 1'b0;
                walk_side_a <= (state == ST_AY);
            end else if (ped_req && state != ST_WALK) begin
                ped_pend <= 1'b1;
            end
        end
    end

    // NOTE: every always_comb output gets a default first so no path
    // through the case can infer a latch.
    always_comb begin
        nxt = state;
        unique case (state)
            ST_AG: begin
                if (cnt >= GMIN_LAST &&
                    (!Ta || (cnt == GMAX_LAST && (Tb || ped_pend))))
                    nxt = ST_AY;
            end
            ST_AY: begin
                if (cnt == YEL_LAST)
                    nxt = ped_pend ? ST_WALK : ST_BG;
            end
            ST_BG: begin
                if (cnt >= GMIN_LAST &&
                    (!Tb || (cnt == GMAX_LAST && (Ta || ped_pend))))
                    nxt = ST_BY;
            end
            ST_BY: begin
                if (cnt == YEL_LAST)
                    nxt = ped_pend ? ST_WALK : ST_AG;
            end
            ST_WALK: begin
                if (cnt == WALK_LAST)
                    nxt = walk_side_a ? ST_BG : ST_AG;
            end
            default: nxt = ST_AG;
        endcase
    end

    always_comb begin
        La      = RED;
        Lb      = RED;
        walk    = 1'b0;
        ped_ack = 1'b0;
        unique case (state)
            ST_AG:   La = GREEN;
            ST_AY:   La = YELLOW;
            ST_BG:   Lb = GREEN;
            ST_BY:   Lb = YELLOW;
            ST_WALK: begin
                walk    = 1'b1;
                ped_ack = (cnt == '0);
            end
            default: begin
                La = GREEN;
            end
        endcase
    end

endmodule

// File: tb/tb_tl_ped_cntr.sv
// Directed testbench for tl_ped_cntr: per-cycle expected phase sequences
// are built by hand and compared against the light, walk and ack outputs.
module tb_tl_ped_cntr;

    localparam logic [1:0] G = 2'b00;
    localparam logic [1:0] Y = 2'b01;
    localparam logic [1:0] R = 2'b10;

    typedef enum int {S_AG, S_AY, S_BG, S_BY, S_WK} st_e;

    logic       clk;
    logic       reset_n;
    logic       Ta;
    logic       Tb;
    logic       ped_req;
    logic [1:0] La;
    logic [1:0] Lb;
    logic       walk;
    logic       ped_ack;

    int vectors;
    int miscompares;

    st_e exp_q[$];
    bit  ped_q[$];

    tl_ped_cntr dut (
        .clk     (clk),
        .reset_n (reset_n),
        .Ta      (Ta),
        .Tb      (Tb),
        .ped_req (ped_req),
        .La      (La),
        .Lb      (Lb),
        .walk    (walk),
        .ped_ack (ped_ack)
    );

    always #5 clk = ~clk;

    task automatic push(input st_e s, input int n, input bit p);
        repeat (n) begin
            exp_q.push_back(s);
            ped_q.push_back(p);
        end
    endtask

    task automatic clear_q();
        exp_q.delete();
        ped_q.delete();
    endtask

    // Reset with given sensor levels; releases on a falling edge so the
    // first sample is the first AG cycle.
    task automatic do_reset(input logic ta, input logic tb);
        reset_n = 1'b0;
        Ta      = ta;
        Tb      = tb;
        ped_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Walks the expected queue one cycle at a time, sampling on falling edges.
    task automatic run_check(input string name);
        logic [1:0] la_e, lb_e;
        logic       wk_e, ack_e;
        for (int i = 0; i < exp_q.size(); i++) begin
            ped_req = ped_q[i];
            la_e = R; lb_e = R; wk_e = 1'b0;
            case (exp_q[i])
                S_AG: la_e = G;
                S_AY: la_e = Y;
                S_BG: lb_e = G;
                S_BY: lb_e = Y;
                S_WK: wk_e = 1'b1;
                default: ;
            endcase
            ack_e = (exp_q[i] == S_WK) && (i == 0 || exp_q[i-1] != S_WK);
            vectors++;
            if ({La, Lb, walk, ped_ack} !== {la_e, lb_e, wk_e, ack_e}) begin
                miscompares++;
                $display("FAIL %s[%0d]: got La=%b Lb=%b walk=%b ack=%b, want La=%b Lb=%b walk=%b ack=%b",
                         name, i, La, Lb, walk, ped_ack, la_e, lb_e, wk_e, ack_e);
            end
            @(negedge clk);
        end
        ped_req = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        Ta      = 1'b1;
        Tb      = 1'b0;
        ped_req = 1'b0;
        #3;
        vectors++;
        if ({La, Lb, walk, ped_ack} !== {G, R, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_hold: got La=%b Lb=%b walk=%b ack=%b, want La=%b Lb=%b walk=0 ack=0",
                     La, Lb, walk, ped_ack, G, R);
        end
        do_reset(1'b1, 1'b0);
        clear_q();
        push(S_AG, 40, 1'b0);
        run_check("a_hold");
    endtask

    task automatic test_a_to_b();
        do_reset(1'b0, 1'b1);
        clear_q();
        push(S_AG, 4, 1'b0);
        push(S_AY, 2, 1'b0);
        push(S_BG, 8, 1'b0);
        run_check("a_to_b");
    endtask

    task automatic test_both_waiting();
        do_reset(1'b1, 1'b1);
        clear_q();
        push(S_AG, 16, 1'b0);
        push(S_AY, 2, 1'b0);
        push(S_BG, 16, 1'b0);
        push(S_BY, 2, 1'b0);
        push(S_AG, 16, 1'b0);
        push(S_AY, 2, 1'b0);
        push(S_BG, 2, 1'b0);
        run_check("green_max");
    endtask

    task automatic test_ped_walk();
        do_reset(1'b0, 1'b1);
        clear_q();
        push(S_AG, 1, 1'b0);
        push(S_AG, 1, 1'b1);
        push(S_AG, 2, 1'b0);
        push(S_AY, 2, 1'b0);
        push(S_WK, 6, 1'b0);
        push(S_BG, 6, 1'b0);
        run_check("ped_walk");
    endtask

    // Request held through walk must not cause a second walk; a later
    // pulse in BG walks from BY and resumes with road A.
    task automatic test_ped_held();
        do_reset(1'b0, 1'b0);
        clear_q();
        push(S_AG, 4, 1'b1);
        push(S_AY, 2, 1'b1);
        push(S_WK, 5, 1'b1);
        push(S_WK, 1, 1'b0);
        push(S_BG, 4, 1'b0);
        push(S_BY, 2, 1'b0);
        push(S_AG, 4, 1'b0);
        push(S_AY, 2, 1'b0);
        push(S_BG, 1, 1'b1);
        push(S_BG, 3, 1'b0);
        push(S_BY, 2, 1'b0);
        push(S_WK, 6, 1'b0);
        push(S_AG, 4, 1'b0);
        push(S_AY, 2, 1'b0);
        push(S_BG, 2, 1'b0);
        run_check("ped_held");
    endtask

    task automatic test_async_reset();
        do_reset(1'b0, 1'b0);
        clear_q();
        push(S_AG, 4, 1'b0);
        push(S_AY, 2, 1'b0);
        push(S_BG, 4, 1'b0);
        push(S_BY, 1, 1'b0);
        run_check("to_by");
        #1 reset_n = 1'b0;
        #1;
        vectors++;
        if ({La, Lb, walk, ped_ack} !== {G, R, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL async_reset: got La=%b Lb=%b walk=%b ack=%b, want La=%b Lb=%b walk=0 ack=0",
                     La, Lb, walk, ped_ack, G, R);
        end
        #2 reset_n = 1'b1;
        @(negedge clk);
        vectors++;
        if ({La, Lb, walk} !== {G, R, 1'b0}) begin
            miscompares++;
            $display("FAIL after_async_reset: got La=%b Lb=%b walk=%b, want La=%b Lb=%b walk=0",
                     La, Lb, walk, G, R);
        end
    endtask

    initial begin
        clk         = 1'b0;
        reset_n     = 1'b0;
        Ta          = 1'b0;
        Tb          = 1'b0;
        ped_req     = 1'b0;
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_a_to_b();
        test_both_waiting();
        test_ped_walk();
        test_ped_held();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
